// File: rtl/i2c_slave_reg_bank_if.sv
// Bundle of I2C_slave-side and host-side signals of the register bank.
// The slave modport is the register bank; the master modport is whatever drives it
// (the I2C_slave byte interface together with the local host logic).
interface i2c_slave_reg_bank_if #(
   parameter int ADDR_W = 4
);
   // I2C_slave byte stream
   logic [7:0]        byte_read_i;
   logic              read_write_flag_i;
   logic              byte_finish_i;
   logic              transmit_busy_i;
   logic              transmit_err_i;
   logic [7:0]        byte_write_o;
   // host access port
   logic [ADDR_W-1:0] host_addr;
   logic              host_wr_en;
   logic [7:0]        host_wdata;
   logic [7:0]        host_rdata;
   // status
   logic              reg_update;
   logic [ADDR_W-1:0] reg_update_addr;
   logic [ADDR_W-1:0] ptr_o;
   logic              bus_err;
   logic [2:0]        dbg_state;

   modport slave (
      input  byte_read_i, read_write_flag_i, byte_finish_i, transmit_busy_i, transmit_err_i,
      input  host_addr, host_wr_en, host_wdata,
      output byte_write_o, host_rdata, reg_update, reg_update_addr, ptr_o, bus_err, dbg_state
   );

   modport master (
      output byte_read_i, read_write_flag_i, byte_finish_i, transmit_busy_i, transmit_err_i,
      output host_addr, host_wr_en, host_wdata,
      input  byte_write_o, host_rdata, reg_update, reg_update_addr, ptr_o, bus_err, dbg_state
   );
endinterface

// File: rtl/i2c_slave_reg_bank.sv
// Register-file back end for an I2C slave byte engine.
// Byte handshake: byte_finish_i is a single-cycle strobe; each cycle it is high
// one byte (and its ACK) is complete and byte_read_i is valid in that same cycle.
// There is no back-pressure: a byte the FSM is not ready for is simply dropped.
// In a write transaction the first byte sets the register pointer and each later
// byte is stored at the pointer, which then increments (wrapping). In a read
// transaction each completed byte advances the pointer; the byte presented for
// transmission is always regs[ptr].
module i2c_slave_reg_bank #(
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   i2c_slave_reg_bank_if.slave   bus
);

   localparam int NREG = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GET_PTR = 3'd1,
      ST_WR_REGS = 3'd2,
      ST_SEND    = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              bus_err_q, bus_err_d;
   logic              reg_update_q, reg_update_d;
   logic [ADDR_W-1:0] reg_update_addr_q, reg_update_addr_d;
   logic [7:0]        regs_q [NREG];
   logic [7:0]        regs_d [NREG];

   logic              busy_rise;
   logic              bus_we;

   assign busy_rise = bus.transmit_busy_i & ~busy_q;
   assign busy_d    = bus.transmit_busy_i;

   // State register and all bank flops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q           <= ST_IDLE;
         busy_q            <= 1'b0;
         ptr_q             <= '0;
         bus_err_q         <= 1'b0;
         reg_update_q      <= 1'b0;
         reg_update_addr_q <= '0;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         state_q           <= state_d;
         busy_q            <= busy_d;
         ptr_q             <= ptr_d;
         bus_err_q         <= bus_err_d;
         reg_update_q      <= reg_update_d;
         reg_update_addr_q <= reg_update_addr_d;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Transaction FSM: busy low beats error, error beats a same-cycle byte
   always_comb begin
      state_d           = state_q;
      ptr_d             = ptr_q;
      bus_err_d         = bus_err_q;
      reg_update_d      = 1'b0;
      reg_update_addr_d = reg_update_addr_q;
      bus_we            = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (busy_rise) begin
               bus_err_d = 1'b0;
               state_d   = bus.read_write_flag_i ? ST_WR_REGS_OR_PTR() : ST_SEND;
            end
         end
         ST_GET_PTR, ST_WR_REGS, ST_SEND: begin
            if (!bus.transmit_busy_i) begin
               state_d = ST_IDLE;
            end else if (bus.transmit_err_i) begin
               bus_err_d = 1'b1;
               state_d   = ST_DRAIN;
            end else if (bus.byte_finish_i) begin
               if (state_q == ST_GET_PTR) begin
                  ptr_d   = bus.byte_read_i[ADDR_W-1:0];
                  state_d = ST_WR_REGS;
               end else if (state_q == ST_WR_REGS) begin
                  bus_we            = 1'b1;
                  reg_update_d      = 1'b1;
                  reg_update_addr_d = ptr_q;
                  ptr_d             = ptr_q + 1'b1;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (!bus.transmit_busy_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A write transaction always starts by collecting the pointer byte
   function automatic state_t ST_WR_REGS_OR_PTR();
      return ST_GET_PTR;
   endfunction

   // Register write merge: host first, bus last so the bus wins on the same index
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (bus.host_wr_en) begin
         regs_d[bus.host_addr] = bus.host_wdata;
      end
      if (bus_we) begin
         regs_d[ptr_q] = bus.byte_read_i;
      end
   end

   assign bus.byte_write_o    = regs_q[ptr_q];
   assign bus.host_rdata      = regs_q[bus.host_addr];
   assign bus.reg_update      = reg_update_q;
   assign bus.reg_update_addr = reg_update_addr_q;
   assign bus.ptr_o           = ptr_q;
   assign bus.bus_err         = bus_err_q;
   assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_i2c_slave_reg_bank.sv
// Directed bench for i2c_slave_reg_bank: pointer load, register writes, read-back
// transmission, pointer wrap, host/bus write collision, error drain and busy-drop.
module tb_i2c_slave_reg_bank;

  localparam int ADDR_W = 4;

  logic clk;
  logic rst_n;

  i2c_slave_reg_bank_if #(.ADDR_W(ADDR_W)) bus ();

  i2c_slave_reg_bank #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every reg_update pulse must match the next expected address
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.reg_update === 1'b1) begin
      if (exp_q.size() == 0) check_eq("unexpected_reg_update", 32'd1, 32'd0);
      else check_eq("reg_update_addr", 32'(bus.reg_update_addr), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic rw);
    bus.transmit_busy_i   = 1'b1;
    bus.read_write_flag_i = rw;
    tick();
  endtask

  task automatic end_txn();
    bus.transmit_busy_i = 1'b0;
    tick();
  endtask

  task automatic byte_pulse(input logic [7:0] data);
    bus.byte_read_i   = data;
    bus.byte_finish_i = 1'b1;
    tick();
    bus.byte_finish_i = 1'b0;
  endtask

  task automatic host_check(input string tag, input logic [ADDR_W-1:0] addr, input logic [7:0] exp);
    bus.host_addr = addr;
    #1;
    check_eq(tag, 32'(bus.host_rdata), 32'(exp));
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.byte_read_i       = 8'h00;
    bus.read_write_flag_i = 1'b0;
    bus.byte_finish_i     = 1'b0;
    bus.transmit_busy_i   = 1'b0;
    bus.transmit_err_i    = 1'b0;
    bus.host_addr         = '0;
    bus.host_wr_en        = 1'b0;
    bus.host_wdata        = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: reset state
    for (int i = 0; i < 16; i++) host_check("reset_reg", ADDR_W'(i), 8'h00);
    check_eq("reset_ptr", 32'(bus.ptr_o), 32'd0);
    check_eq("reset_bus_err", 32'(bus.bus_err), 32'd0);
    check_eq("reset_reg_update", 32'(bus.reg_update), 32'd0);
    check_eq("reset_state", 32'(bus.dbg_state), 32'd0);

    // 2: pointer 05, write AA, BB
    start_txn(1'b1);
    check_eq("state_get_ptr", 32'(bus.dbg_state), 32'd1);
    byte_pulse(8'h05);
    check_eq("ptr_loaded", 32'(bus.ptr_o), 32'd5);
    exp_q.push_back(4'd5);
    byte_pulse(8'hAA);
    exp_q.push_back(4'd6);
    byte_pulse(8'hBB);
    host_check("wr_reg5", 4'd5, 8'hAA);
    host_check("wr_reg6", 4'd6, 8'hBB);
    check_eq("wr_ptr7", 32'(bus.ptr_o), 32'd7);
    end_txn();

    // 3: set pointer 05, repeated start, read back
    start_txn(1'b1);
    byte_pulse(8'h05);
    end_txn();
    start_txn(1'b0);
    check_eq("state_send", 32'(bus.dbg_state), 32'd3);
    check_eq("rd_byte0", 32'(bus.byte_write_o), 32'hAA);
    byte_pulse(8'h00);
    check_eq("rd_byte1", 32'(bus.byte_write_o), 32'hBB);
    check_eq("rd_ptr6", 32'(bus.ptr_o), 32'd6);
    end_txn();
    host_check("rd_reg5_kept", 4'd5, 8'hAA);
    host_check("rd_reg6_kept", 4'd6, 8'hBB);

    // 4: pointer wrap, upper bits of pointer byte ignored
    start_txn(1'b1);
    byte_pulse(8'hFF);
    check_eq("wrap_ptr_f", 32'(bus.ptr_o), 32'd15);
    exp_q.push_back(4'd15);
    byte_pulse(8'h11);
    exp_q.push_back(4'd0);
    byte_pulse(8'h22);
    end_txn();
    host_check("wrap_reg15", 4'd15, 8'h11);
    host_check("wrap_reg0", 4'd0, 8'h22);
    check_eq("wrap_ptr1", 32'(bus.ptr_o), 32'd1);

    // 5: host/bus collisions
    start_txn(1'b1);
    byte_pulse(8'h03);
    exp_q.push_back(4'd3);
    bus.host_wr_en = 1'b1;
    bus.host_addr  = 4'd3;
    bus.host_wdata = 8'h77;
    byte_pulse(8'h44);
    exp_q.push_back(4'd4);
    bus.host_addr  = 4'd9;
    bus.host_wdata = 8'h55;
    byte_pulse(8'hC3);
    bus.host_wr_en = 1'b0;
    host_check("coll_same_bus_wins", 4'd3, 8'h44);
    host_check("coll_diff_bus", 4'd4, 8'hC3);
    host_check("coll_diff_host", 4'd9, 8'h55);
    // busy drop beats a same-cycle byte
    bus.transmit_busy_i = 1'b0;
    byte_pulse(8'hDD);
    host_check("busy_drop_reg5", 4'd5, 8'hAA);
    check_eq("busy_drop_ptr", 32'(bus.ptr_o), 32'd5);
    check_eq("busy_drop_idle", 32'(bus.dbg_state), 32'd0);
    // plain host write
    bus.host_wr_en = 1'b1;
    bus.host_addr  = 4'd4;
    bus.host_wdata = 8'h55;
    tick();
    bus.host_wr_en = 1'b0;
    host_check("host_wr_reg4", 4'd4, 8'h55);

    // 6: error mid-write, then drain
    start_txn(1'b1);
    byte_pulse(8'h0A);
    exp_q.push_back(4'd10);
    byte_pulse(8'h12);
    bus.transmit_err_i = 1'b1;
    byte_pulse(8'hE1);
    bus.transmit_err_i = 1'b0;
    check_eq("err_set", 32'(bus.bus_err), 32'd1);
    check_eq("err_drain", 32'(bus.dbg_state), 32'd4);
    byte_pulse(8'hE2);
    byte_pulse(8'hE3);
    host_check("err_reg10", 4'd10, 8'h12);
    host_check("err_reg11", 4'd11, 8'h00);
    host_check("err_reg12", 4'd12, 8'h00);
    check_eq("err_ptr", 32'(bus.ptr_o), 32'd11);
    end_txn();
    check_eq("err_sticky", 32'(bus.bus_err), 32'd1);
    start_txn(1'b0);
    check_eq("err_cleared", 32'(bus.bus_err), 32'd0);
    check_eq("err_rd_byte", 32'(bus.byte_write_o), 32'h00);
    end_txn();

    tick();
    tick();
    check_eq("updates_all_seen", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
